// File: rtl/cb_config_loader_if.sv
// Configuration stream handshake between the bitstream source and the loader.
// The source drives start/valid/data; the loader reports ready/busy/done/error.
interface cb_config_loader_if #(
    parameter int CFG_W = 8
);
    logic             cfg_start;
    logic             cfg_valid;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_ready;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_error;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready, cfg_busy, cfg_done, cfg_error
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready, cfg_busy, cfg_done, cfg_error
    );
endinterface

// File: rtl/cb_config_loader.sv
// Word-serial loader for connection-block gate enables: assembles a shadow frame,
// verifies its XOR checksum, then commits it to the active controls in one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for cfg_start
// S_LOAD  | accepting frame words into the shadow register
// S_CHECK | next accepted word is the checksum
// S_DONE  | frame committed, held until cfg_start
// S_ERROR | checksum mismatch, active controls untouched
module cb_config_loader #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int NUM_TILES     = 1,
    parameter int CFG_W         = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    cb_config_loader_if.slave                    cfg,
    output logic [NUM_TILES*CHANNEL_WIDTH/2-1:0] v_ctrl1,
    output logic [NUM_TILES*CHANNEL_WIDTH/2-1:0] v_ctrl3,
    output logic [NUM_TILES*CHANNEL_WIDTH/2-1:0] h_ctrl0,
    output logic [NUM_TILES*CHANNEL_WIDTH/2-1:0] h_ctrl2,
    output logic [NUM_TILES*CHANNEL_WIDTH/2-1:0] h_ctrl4
);
    localparam int HALF       = CHANNEL_WIDTH / 2;
    localparam int TILE_BITS  = 5 * HALF;
    localparam int TOTAL_BITS = NUM_TILES * TILE_BITS;
    localparam int NUM_WORDS  = (TOTAL_BITS + CFG_W - 1) / CFG_W;
    localparam int CNT_W      = $clog2(NUM_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        word_cnt;
    logic [CFG_W-1:0]        csum;
    logic [TOTAL_BITS-1:0]   shadow, shadow_d;
    logic [TOTAL_BITS-1:0]   active;
    logic                    xfer, load_xfer, csum_ok;

    assign cfg.cfg_ready = (state == S_LOAD) || (state == S_CHECK);
    assign cfg.cfg_busy  = cfg.cfg_ready;
    assign cfg.cfg_done  = (state == S_DONE);
    assign cfg.cfg_error = (state == S_ERROR);

    // A restart request takes priority over a word offered in the same cycle.
    assign xfer      = cfg.cfg_valid && cfg.cfg_ready && !cfg.cfg_start;
    assign load_xfer = xfer && (state == S_LOAD);
    assign csum_ok   = (cfg.cfg_data == csum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cfg.cfg_start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (xfer && (word_cnt == CNT_W'(NUM_WORDS - 1))) state_nxt = S_CHECK;
                S_CHECK: if (xfer) state_nxt = csum_ok ? S_DONE : S_ERROR;
                default: state_nxt = state;
            endcase
        end
    end

    // Each shadow bit belongs to one word slot; bits past TOTAL_BITS have no storage.
    for (genvar j = 0; j < TOTAL_BITS; j++) begin : g_shadow
        assign shadow_d[j] = (load_xfer && (word_cnt == CNT_W'(j / CFG_W)))
                           ? cfg.cfg_data[j % CFG_W] : shadow[j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            active   <= '0;
            word_cnt <= '0;
            csum     <= '0;
        end else if (cfg.cfg_start) begin
            word_cnt <= '0;
            csum     <= '0;
        end else begin
            shadow <= shadow_d;
            if (load_xfer) begin
                csum     <= csum ^ cfg.cfg_data;
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (xfer && (state == S_CHECK) && csum_ok) begin
                active <= shadow;
            end
        end
    end

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        assign v_ctrl1[t*HALF +: HALF] = active[t*TILE_BITS + 0*HALF +: HALF];
        assign v_ctrl3[t*HALF +: HALF] = active[t*TILE_BITS + 1*HALF +: HALF];
        assign h_ctrl0[t*HALF +: HALF] = active[t*TILE_BITS + 2*HALF +: HALF];
        assign h_ctrl2[t*HALF +: HALF] = active[t*TILE_BITS + 3*HALF +: HALF];
        assign h_ctrl4[t*HALF +: HALF] = active[t*TILE_BITS + 4*HALF +: HALF];
    end
endmodule
